// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, FSM states, mux select and ALU encodings.
// Latency: n/a (constants, types and pure combinational helpers only).
// Backpressure: n/a.
package riscv_pkg;

  // Major opcodes (instr[6:0]) recognised by the multicycle controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_t;

  // Encodings shared with the extend unit
  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  // Coarse ALU request from the FSM; FUNCT defers to funct3/funct7b5
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // Immediate format is a pure function of the opcode (shifts need shamt)
  function automatic logic [2:0] imm_src_of(input logic [6:0] op, input logic [2:0] funct3);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_LOAD, OP_JALR: imm = IMM_I;
      OP_IMM:           imm = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
      OP_STORE:         imm = IMM_S;
      OP_BRANCH:        imm = IMM_B;
      OP_JAL:           imm = IMM_J;
      OP_LUI, OP_AUIPC: imm = IMM_U;
      default:          imm = IMM_I;
    endcase
    return imm;
  endfunction

  // Encodings the datapath can execute; everything else traps
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] funct3,
                                    input logic funct7b5);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD:   ok = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      OP_STORE:  ok = (funct3 <= 3'b010);
      OP_BRANCH: ok = !(funct3 == 3'b010 || funct3 == 3'b011);
      OP_R:      ok = !funct7b5 || funct3 == 3'b000 || funct3 == 3'b101;
      OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: maps FSM ALU request plus funct fields to ALUControl.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  // funct7b5 selects SUB only for register-register adds (op5=1); for
  // immediates bit 30 is part of the immediate except on right shifts
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle RV32I datapath (selects, enables, ALU op, ImmSrc).
// Latency: one state per cycle; lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui/auipc 3.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE with mem_req high until mem_ready.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal_instr
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       branch_taken;

  // Next-state logic; DECODE sends every unsupported encoding to TRAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!is_legal(op, funct3, funct7b5)) begin
          state_d = S_TRAP;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_IMM:            state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            OP_AUIPC:          state_d = S_ALUWB;
            default:           state_d = S_TRAP;
          endcase
        end
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch condition from ALU flags; funct3 010/011 never reach BRANCH
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = !lt;
      3'b110:  branch_taken = ltu;
      3'b111:  branch_taken = !ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  // Per-state datapath controls; enables are suppressed while reset is held
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        PCWrite = branch_taken;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link address
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ResultSrc = RES_IMMEXT;
        RegWrite  = 1'b1;
      end
      default: begin
      end
    endcase
    if (!rst_n) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // Immediate format tracks the opcode in every state
  always_comb begin
    ImmSrc = imm_src_of(op, funct3);
  end

  // TRAP is absorbing, so the indicator stays set until reset
  always_comb begin
    illegal_instr = (state_q == S_TRAP);
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected control trace vs DUT.
// Latency: checks every cycle at the falling edge.
// Backpressure: mem_ready wait states are scripted per instruction.
module tb_multicycle_controller;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_IMM    = 7'b0010011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_FENCE  = 7'b0001111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       illegal;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n, zero, lt, ltu, mem_ready, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  obs_t       act;

  int n_tests = 0;
  int n_fail  = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  logic [6:0] cur_op = '0;
  logic [2:0] cur_f3 = '0;
  logic       cur_f7 = 1'b0;
  logic       cur_z = 1'b0, cur_l = 1'b0, cur_lu = 1'b0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_instr};

  // ---------------- model: rules written per instruction class ----------------
  function automatic logic [2:0] imm_of(input logic [6:0] o, input logic [2:0] f3);
    if (o == T_LOAD || o == T_JALR) return 3'd0;
    if (o == T_IMM) return (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
    if (o == T_STORE) return 3'd1;
    if (o == T_BRANCH) return 3'd2;
    if (o == T_JAL) return 3'd3;
    if (o == T_LUI || o == T_AUIPC) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic legal(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (o == T_LOAD) return !(f3 inside {3'd3, 3'd6, 3'd7});
    if (o == T_STORE) return f3 < 3'd3;
    if (o == T_BRANCH) return !(f3 inside {3'd2, 3'd3});
    if (o == T_R) return !f7 || f3 == 3'd0 || f3 == 3'd5;
    return o inside {T_IMM, T_JAL, T_JALR, T_LUI, T_AUIPC};
  endfunction

  // ALU code of the arithmetic an R/I instruction asks for
  function automatic logic [3:0] alu_of(input logic isr, input logic [2:0] f3, input logic f7);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (f3 == 3'd0 && isr && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd9;
    return tbl[f3];
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    logic c;
    c = (f3[2:1] == 2'b00) ? z : (f3[2:1] == 2'b10) ? l : lu;
    return f3[0] ? !c : c;
  endfunction

  function automatic obs_t r_base();
    obs_t o;
    o = '0;
    o.imm = imm_of(cur_op, cur_f3);
    return o;
  endfunction

  function automatic obs_t r_fetch(input logic mr);
    obs_t o;
    o = r_base(); o.mem_req = 1'b1; o.src_b = 2'd2; o.result_src = 2'd2;
    o.ir_write = mr; o.pc_write = mr;
    return o;
  endfunction

  function automatic obs_t r_ab(input logic [1:0] a, input logic [1:0] b);
    obs_t o;
    o = r_base(); o.src_a = a; o.src_b = b;
    return o;
  endfunction

  function automatic obs_t r_mem(input logic wr);
    obs_t o;
    o = r_base(); o.mem_req = 1'b1; o.mem_write = wr; o.adr_src = 1'b1;
    return o;
  endfunction

  function automatic obs_t r_wb(input logic [1:0] rs);
    obs_t o;
    o = r_base(); o.reg_write = 1'b1; o.result_src = rs;
    return o;
  endfunction

  function automatic obs_t r_exec(input logic isr);
    obs_t o;
    o = r_ab(2'd2, isr ? 2'd0 : 2'd1); o.alu = alu_of(isr, cur_f3, cur_f7);
    return o;
  endfunction

  function automatic obs_t r_branch();
    obs_t o;
    o = r_ab(2'd2, 2'd0); o.alu = 4'd1; o.pc_write = taken(cur_f3, cur_z, cur_l, cur_lu);
    return o;
  endfunction

  function automatic obs_t r_jal();
    obs_t o;
    o = r_ab(2'd1, 2'd2); o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic obs_t r_trap();
    obs_t o;
    o = r_base(); o.illegal = 1'b1;
    return o;
  endfunction

  function automatic obs_t in_reset(input obs_t e);
    obs_t o;
    o = e; o.mem_req = 0; o.mem_write = 0; o.ir_write = 0; o.pc_write = 0; o.reg_write = 0;
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic rn, input logic mr, input obs_t e, input string tg);
    @(posedge clk); #1;
    rst_n = rn; mem_ready = mr; op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
    zero = cur_z; lt = cur_l; ltu = cur_lu;
    exp_q.push_back(e); tag_q.push_back(tg);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic l, input logic lu);
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_l = l; cur_lu = lu;
  endtask

  task automatic lit(input string nm, input int actv, input int expv);
    n_tests++;
    if (actv != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, actv, expv);
    end
  endtask

  // Full instruction; for illegal encodings mwait is the number of TRAP cycles observed
  task automatic do_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input int fwait, input int mwait,
                          input logic z, input logic l, input logic lu);
    set_instr(o, f3, f7, z, l, lu);
    repeat (fwait) step(1, 0, r_fetch(0), {nm, " fetch-wait"});
    step(1, 1, r_fetch(1), {nm, " fetch"});
    step(1, 0, r_ab(2'd1, 2'd1), {nm, " decode"});
    if (!legal(o, f3, f7)) begin
      repeat (mwait) step(1, 0, r_trap(), {nm, " trap"});
    end else begin
      case (o)
        T_LOAD, T_STORE: begin
          step(1, 0, r_ab(2'd2, 2'd1), {nm, " adr"});
          repeat (mwait) step(1, 0, r_mem(o == T_STORE), {nm, " mem-wait"});
          step(1, 1, r_mem(o == T_STORE), {nm, " mem"});
          if (o == T_LOAD) step(1, 0, r_wb(2'd1), {nm, " memwb"});
        end
        T_R:      begin step(1, 0, r_exec(1), {nm, " exec"}); step(1, 0, r_wb(2'd0), {nm, " wb"}); end
        T_IMM:    begin step(1, 0, r_exec(0), {nm, " exec"}); step(1, 0, r_wb(2'd0), {nm, " wb"}); end
        T_BRANCH: step(1, 0, r_branch(), {nm, " branch"});
        T_JAL:    begin step(1, 0, r_jal(), {nm, " jal"}); step(1, 0, r_wb(2'd0), {nm, " wb"}); end
        T_JALR: begin
          step(1, 0, r_ab(2'd2, 2'd1), {nm, " jalr"});
          step(1, 0, r_jal(), {nm, " jal"});
          step(1, 0, r_wb(2'd0), {nm, " wb"});
        end
        T_LUI:    step(1, 0, r_wb(2'd3), {nm, " lui"});
        default:  step(1, 0, r_wb(2'd0), {nm, " wb"});
      endcase
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    obs_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: dut=%05h model=%05h", t, act, e);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 0; mem_ready = 0; op = '0; funct3 = '0; funct7b5 = 0; zero = 0; lt = 0; ltu = 0;
    step(0, 0, in_reset(r_fetch(0)), "reset0");
    step(0, 1, in_reset(r_fetch(1)), "reset1");
    @(negedge clk);
    lit("reset mem_req", mem_req, 0);
    lit("reset IRWrite", IRWrite, 0);
    lit("reset illegal", illegal_instr, 0);

    do_instr("lui", T_LUI, 3'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    lit("lui ImmSrc", ImmSrc, 4);
    lit("lui ResultSrc", ResultSrc, 3);
    lit("lui RegWrite", RegWrite, 1);

    do_instr("lw", T_LOAD, 3'd2, 0, 0, 2, 0, 0, 0);
    @(negedge clk);
    lit("lw memwb RegWrite", RegWrite, 1);
    lit("lw memwb ResultSrc", ResultSrc, 1);

    do_instr("bne z1", T_BRANCH, 3'd1, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    lit("bne z1 PCWrite", PCWrite, 0);
    lit("bne ALUControl", ALUControl, 1);
    lit("bne ImmSrc", ImmSrc, 2);
    do_instr("bne z0", T_BRANCH, 3'd1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    lit("bne z0 PCWrite", PCWrite, 1);
    do_instr("beq z1", T_BRANCH, 3'd0, 0, 0, 0, 1, 0, 0);
    do_instr("blt lt1", T_BRANCH, 3'd4, 0, 0, 0, 0, 1, 0);
    do_instr("bge lt1", T_BRANCH, 3'd5, 0, 0, 0, 0, 1, 0);
    do_instr("bgeu ltu0", T_BRANCH, 3'd7, 0, 0, 0, 0, 0, 0);

    // srai: pin the EXEC cycle directly
    set_instr(T_IMM, 3'd5, 1, 0, 0, 0);
    step(1, 1, r_fetch(1), "srai fetch");
    step(1, 0, r_ab(2'd1, 2'd1), "srai decode");
    step(1, 0, r_exec(0), "srai exec");
    @(negedge clk);
    lit("srai ALUControl", ALUControl, 9);
    lit("srai ImmSrc", ImmSrc, 5);
    step(1, 0, r_wb(2'd0), "srai wb");

    set_instr(T_IMM, 3'd0, 1, 0, 0, 0);
    step(1, 1, r_fetch(1), "addi fetch");
    step(1, 0, r_ab(2'd1, 2'd1), "addi decode");
    step(1, 0, r_exec(0), "addi exec");
    @(negedge clk);
    lit("addi f7 ALUControl", ALUControl, 0);
    step(1, 0, r_wb(2'd0), "addi wb");

    do_instr("sub", T_R, 3'd0, 1, 0, 0, 0, 0, 0);
    do_instr("sra", T_R, 3'd5, 1, 1, 0, 0, 0, 0);
    do_instr("sltu", T_R, 3'd3, 0, 0, 0, 0, 0, 0);
    do_instr("ori", T_IMM, 3'd6, 0, 0, 0, 0, 0, 0);
    do_instr("sw", T_STORE, 3'd2, 0, 1, 1, 0, 0, 0);
    do_instr("jal", T_JAL, 3'd0, 0, 0, 0, 0, 0, 0);
    do_instr("jalr", T_JALR, 3'd0, 0, 0, 0, 0, 0, 0);
    do_instr("auipc", T_AUIPC, 3'd0, 0, 0, 0, 0, 0, 0);

    // reset while a store waits on memory
    set_instr(T_STORE, 3'd0, 0, 0, 0, 0);
    step(1, 1, r_fetch(1), "sb fetch");
    step(1, 0, r_ab(2'd1, 2'd1), "sb decode");
    step(1, 0, r_ab(2'd2, 2'd1), "sb adr");
    step(1, 0, r_mem(1), "sb mem-wait");
    step(0, 0, in_reset(r_mem(1)), "sb reset");
    @(negedge clk);
    lit("abort MemWrite", MemWrite, 0);
    lit("abort mem_req", mem_req, 0);
    step(1, 0, r_fetch(0), "after abort fetch");

    do_instr("fence", T_FENCE, 3'd0, 0, 0, 10, 0, 0, 0);
    @(negedge clk);
    lit("trap illegal", illegal_instr, 1);
    step(0, 0, in_reset(r_trap()), "trap reset");
    step(1, 0, r_fetch(0), "post-trap fetch");
    @(negedge clk);
    lit("post-trap illegal", illegal_instr, 0);
    lit("post-trap mem_req", mem_req, 1);

    do_instr("lw f3=011", T_LOAD, 3'd3, 0, 0, 3, 0, 0, 0);
    step(0, 0, in_reset(r_trap()), "trap reset 2");
    do_instr("R f7 f3=001", T_R, 3'd1, 1, 0, 2, 0, 0, 0);
    step(0, 0, in_reset(r_trap()), "trap reset 3");
    do_instr("lui again", T_LUI, 3'd0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
